// File: rtl/fetch_unit.sv
// Instruction fetch: owns fetch PC, reads imem combinationally, queues {pc, instr} for decode.
// Latency: 1 cycle imem-to-head when the queue is empty; redirect target at head 2 edges after sampling.
// Backpressure: if_ready low fills the queue in DEPTH cycles, then fetch_pc stalls on the first unfetched word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction_read,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        if_ready
);

  // DEPTH must be a power of two >= 2 so the pointers wrap by plain overflow.
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          pop_req;
  logic          pop;
  logic          push;
  logic [31:0]   redirect_aligned;

  // Handshake decode: a redirect flushes the queue, so it cancels both push and pop.
  always_comb begin
    pop_req          = if_valid && if_ready;
    pop              = pop_req && !redirect_valid;
    push             = !redirect_valid && ((count < DEPTH_C) || pop_req);
    redirect_aligned = {redirect_pc[31:2], 2'b00};
  end

  assign instruction_addr = fetch_pc;
  assign if_valid         = (count != '0);
  assign if_pc            = fifo_pc[rd_ptr];
  assign if_instr         = fifo_instr[rd_ptr];
  assign if_pc_plus4      = if_pc + 32'd4;

  // Fetch PC, queue pointers and occupancy; redirect resets the queue and retargets fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; cleared on reset so the head outputs are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= instruction_read;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_addr;
  logic [31:0] instruction_read;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_ready;

  // second instance exercising PC wrap from a high reset address
  logic [31:0] w_addr;
  logic [31:0] w_read;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb instruction_read = imem_word(instruction_addr);
  always_comb w_read           = imem_word(w_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction_addr (instruction_addr),
    .instruction_read (instruction_read),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .if_ready         (if_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction_addr (w_addr),
    .instruction_read (w_read),
    .redirect_valid   (1'b0),
    .redirect_pc      (32'h0000_0000),
    .if_valid         (w_valid),
    .if_instr         (w_instr),
    .if_pc            (w_pc),
    .if_pc_plus4      (w_pc4),
    .if_ready         (1'b1)
  );

  // One clock of stimulus; the reference queue advances by the stated push/pop/flush rules.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
    int sz;
    bit pop;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = tgt;
    @(posedge clk);
    sz  = q.size();
    pop = (sz != 0) && rdy;
    if (rv) begin
      q.delete();
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (sz < DEPTH || pop) begin
        q.push_back('{pc: m_pc, instr: imem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  // Async reset pulse, released away from the clock edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    q.delete();
    m_pc = 32'h0000_0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'd4 || instruction_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_values: valid=%b instr=%h pc=%h pc4=%h addr=%h, want 0/0/0/4/0", if_valid, if_instr, if_pc, if_pc_plus4, instruction_addr);
    end
    apply_reset();
    n_cmp++;
    if (if_valid !== 1'b0 || instruction_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_release: valid=%b addr=%h, want 0 and 0", if_valid, instruction_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== imem_word(32'(4 * i))) begin
        n_bad++;
        $display("FAIL stream_head[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, if_valid, if_pc, if_instr, 32'(4 * i), imem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (instruction_addr !== 32'd16 || q.size() != DEPTH) begin
      n_bad++;
      $display("FAIL bp_stall_addr: addr=%h model_count=%0d, want 00000010 and %0d", instruction_addr, q.size(), DEPTH);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== imem_word(32'(4 * i))) begin
        n_bad++;
        $display("FAIL bp_drain[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, if_valid, if_pc, if_instr, 32'(4 * i), imem_word(32'(4 * i)));
      end
      step(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'($urandom_range(0, 1)), 1'b1, 32'h0000_0103);
    n_cmp++;
    if (if_valid !== 1'b0 || instruction_addr !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL redir_gap: valid=%b addr=%h, want 0 and 00000100", if_valid, instruction_addr);
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0000_0100 || if_instr !== imem_word(32'h0000_0100)) begin
      n_bad++;
      $display("FAIL redir_target: valid=%b pc=%h instr=%h, want 1 00000100 %h", if_valid, if_pc, if_instr, imem_word(32'h0000_0100));
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (if_pc !== 32'h0000_0104 || if_pc_plus4 !== 32'h0000_0108) begin
      n_bad++;
      $display("FAIL redir_follow: pc=%h pc4=%h, want 00000104 00000108", if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_full_redirect_pop();
    logic [31:0] tgt;
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    tgt = $urandom;
    step(1'b1, 1'b1, tgt);
    n_cmp++;
    if (if_valid !== 1'b0 || instruction_addr !== {tgt[31:2], 2'b00}) begin
      n_bad++;
      $display("FAIL full_redir_flush: valid=%b addr=%h, want 0 and %h", if_valid, instruction_addr, {tgt[31:2], 2'b00});
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== {tgt[31:2], 2'b00}) begin
      n_bad++;
      $display("FAIL full_redir_head: valid=%b pc=%h, want 1 and %h", if_valid, if_pc, {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    n_cmp++;
    if (w_addr !== 32'hFFFF_FFF8 || w_valid !== 1'b0 || w_pc4 !== 32'd4) begin
      n_bad++;
      $display("FAIL wrap_reset: addr=%h valid=%b pc4=%h, want fffffff8 0 00000004", w_addr, w_valid, w_pc4);
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8 || w_instr !== imem_word(32'hFFFF_FFF8)) begin
      n_bad++;
      $display("FAIL wrap_first: valid=%b pc=%h instr=%h, want 1 fffffff8 %h", w_valid, w_pc, w_instr, imem_word(32'hFFFF_FFF8));
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL wrap_last: pc=%h pc4=%h, want fffffffc 00000000", w_pc, w_pc4);
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (w_pc !== 32'h0000_0000 || w_instr !== imem_word(32'h0000_0000)) begin
      n_bad++;
      $display("FAIL wrap_zero: pc=%h instr=%h, want 00000000 %h", w_pc, w_instr, imem_word(32'h0));
    end
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'd4 || instruction_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL midreset_values: valid=%b instr=%h pc=%h pc4=%h addr=%h, want 0/0/0/4/0", if_valid, if_instr, if_pc, if_pc_plus4, instruction_addr);
    end
    apply_reset();
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || instruction_addr !== 32'd4) begin
      n_bad++;
      $display("FAIL midreset_restart: valid=%b pc=%h addr=%h, want 1 00000000 00000004", if_valid, if_pc, instruction_addr);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), $urandom);
      n_cmp++;
      if (if_valid !== (q.size() != 0) || instruction_addr !== m_pc) begin
        n_bad++;
        $display("FAIL rnd_state[%0d]: valid=%b addr=%h, want %b %h", i, if_valid, instruction_addr, (q.size() != 0), m_pc);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if (if_pc !== q[0].pc || if_instr !== q[0].instr || if_pc_plus4 !== q[0].pc + 32'd4) begin
          n_bad++;
          $display("FAIL rnd_head[%0d]: pc=%h instr=%h pc4=%h, want %h %h %h", i, if_pc, if_instr, if_pc_plus4, q[0].pc, q[0].instr, q[0].pc + 32'd4);
        end
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    m_pc           = '0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_full_redirect_pop();
    test_wrap();
    test_midstream_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
